// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial input and the received-byte output bus of
// the UART receiver.
//
// Signals:
//   rx          serial line into the receiver (idle high, asynchronous to clk)
//   dout        last received data word, LSB = first data bit on the line
//   dout_vld    one-clk strobe marking a completed frame
//   parity_err  parity mismatch for the frame flagged by dout_vld
//   frame_err   stop bit sampled low for the frame flagged by dout_vld
//   busy        receiver is inside a frame (start detect until back in IDLE)
//   state_dbg   current receiver FSM state, for observation only
//
// Handshake: dout_vld is a valid-only strobe with no ready. The consumer
// must take dout/parity_err/frame_err in the cycle dout_vld is high; those
// three hold their value until the next dout_vld, and a new frame simply
// overwrites them.
//
// Modports:
//   master  the receiver (drives the byte bus, reads rx)
//   slave   the pin driver / consumer (drives rx, reads the byte bus)
interface uart_rx_if #(
  parameter int DO_WIDTH = 8
) ();
  logic                rx;
  logic [DO_WIDTH-1:0] dout;
  logic                dout_vld;
  logic                parity_err;
  logic                frame_err;
  logic                busy;
  logic [2:0]          state_dbg;

  modport master (
    input  rx,
    output dout,
    output dout_vld,
    output parity_err,
    output frame_err,
    output busy,
    output state_dbg
  );

  modport slave (
    output rx,
    input  dout,
    input  dout_vld,
    input  parity_err,
    input  frame_err,
    input  busy,
    input  state_dbg
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//
// The asynchronous rx line is brought into the clk domain through a 2-flop
// synchronizer. A falling edge while idle starts a frame; the start bit is
// re-checked at its midpoint (glitch reject), then every data bit, the
// optional even-parity bit and the stop bit are sampled at their midpoints.
// The received word is published with a one-clk dout_vld strobe together
// with parity and framing error flags.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   uart_rx_if.master: rx in; dout, dout_vld, parity_err, frame_err,
//         busy and state_dbg out (all outputs registered)
module uart_rx #(
  parameter int CLK_FREQ   = 16_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int PARITY     = 1,
  parameter int DO_WIDTH   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  // clk cycles per oversample tick (integer-truncated)
  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int BW       = $clog2(DO_WIDTH + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMP_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DO_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e              state_q,      state_d;
  logic                rx_meta_q,    rx_meta_d;
  logic                rx_s_q,       rx_s_d;
  logic                rx_prev_q,    rx_prev_d;
  logic [TW-1:0]       tick_cnt_q,   tick_cnt_d;
  logic [SW-1:0]       smp_cnt_q,    smp_cnt_d;
  logic [BW-1:0]       bit_cnt_q,    bit_cnt_d;
  logic [DO_WIDTH-1:0] shift_q,      shift_d;
  logic                perr_q,       perr_d;
  logic [DO_WIDTH-1:0] dout_q,       dout_d;
  logic                dout_vld_q,   dout_vld_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q,  frame_err_d;
  logic                busy_q,       busy_d;

  logic tick;
  logic mid_bit;
  logic fall;

  // The tick divider only runs inside a frame; in IDLE it sits at 0 so the
  // first tick lands exactly TICK_DIV clks after the detected start edge.
  assign tick    = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
  // Data/parity/stop sampling: a full bit after the mid-start re-check,
  // which places every sample at the middle of its bit.
  assign mid_bit = tick && (smp_cnt_q == SMP_LAST);
  assign fall    = rx_prev_q && !rx_s_q;

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = bus.rx;
    rx_s_d       = rx_meta_q;
    rx_prev_d    = rx_s_q;
    tick_cnt_d   = tick_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;

    // tick divider
    if (state_q == S_IDLE || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    // sample counter, wraps every OVERSAMPLE ticks
    if (tick) begin
      smp_cnt_d = (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + SW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d    = S_START;
          busy_d     = 1'b1;
          tick_cnt_d = '0;
          smp_cnt_d  = '0;
        end
      end

      S_START: begin
        if (tick && smp_cnt_q == SMP_HALF) begin
          smp_cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            // line went back high before mid start bit: a glitch
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (mid_bit) begin
          // LSB arrives first, so shift in from the top
          shift_d   = {rx_s_q, shift_q[DO_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (mid_bit) begin
          // even parity: sample plus data bits must XOR to 0
          perr_d  = rx_s_q ^ (^shift_q);
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (mid_bit) begin
          dout_d       = shift_q;
          dout_vld_d   = 1'b1;
          parity_err_d = (PARITY != 0) ? perr_q : 1'b0;
          frame_err_d  = !rx_s_q;
          if (rx_s_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // line held low past the stop bit; wait for it to return high
        // before arming start detection again
        if (rx_s_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      tick_cnt_q   <= '0;
      smp_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      tick_cnt_q   <= tick_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx. Two receivers are built, one with a parity
// bit and one without, and fed serial frames bit by bit. Each sent frame
// pushes its expected word and flags into a queue; a monitor per receiver
// pops and compares whenever dout_vld is seen.
module tb_uart_rx;
  localparam int BAUD    = 9600;
  localparam int OS      = 16;
  localparam int TDIV    = 4;
  localparam int CLKF    = BAUD * OS * TDIV;
  localparam int BIT_CLK = TDIV * OS;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if #(.DO_WIDTH(8)) if_p ();
  uart_rx_if #(.DO_WIDTH(8)) if_n ();

  uart_rx #(
    .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .PARITY(1), .DO_WIDTH(8), .OVERSAMPLE(OS)
  ) u_dut_p (
    .clk(clk), .rst(rst), .bus(if_p)
  );

  uart_rx #(
    .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .PARITY(0), .DO_WIDTH(8), .OVERSAMPLE(OS)
  ) u_dut_n (
    .clk(clk), .rst(rst), .bus(if_n)
  );

  // scoreboard: {frame_err, parity_err, data}
  logic [9:0] exp_p[$];
  logic [9:0] exp_n[$];
  int vld_cyc_p[$];
  int vld_cyc_n[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_check(input bit sel, input logic [7:0] d, input logic pe,
                           input logic fe, input logic bz);
    logic [9:0] e;
    int         n;
    string      tag;
    tag = sel ? "np" : "p";
    if (sel) begin
      vld_cyc_n.push_back(cyc);
      n = exp_n.size();
    end else begin
      vld_cyc_p.push_back(cyc);
      n = exp_p.size();
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_vld_%s: got dout_vld=1 dout=0x%0h expected no frame", tag, d);
    end else begin
      if (sel) e = exp_n.pop_front();
      else     e = exp_p.pop_front();
      chk({"dout_", tag},       32'(d),  32'(e[7:0]));
      chk({"parity_err_", tag}, 32'(pe), 32'(e[8]));
      chk({"frame_err_", tag},  32'(fe), 32'(e[9]));
      // a good frame returns to idle with the strobe, a bad stop keeps busy
      chk({"busy_at_vld_", tag}, 32'(bz), 32'(e[9]));
    end
  endtask

  always @(negedge clk)
    if (if_p.dout_vld === 1'b1)
      mon_check(1'b0, if_p.dout, if_p.parity_err, if_p.frame_err, if_p.busy);

  always @(negedge clk)
    if (if_n.dout_vld === 1'b1)
      mon_check(1'b1, if_n.dout, if_n.parity_err, if_n.frame_err, if_n.busy);

  // driver tasks (called at a negedge, return at a negedge)
  task automatic set_rx(input bit sel, input logic b);
    if (sel) if_n.rx = b;
    else     if_p.rx = b;
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    set_rx(sel, b);
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle(input bit sel, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(sel, 1'b1);
  endtask

  // Reference: the word is the data as sent; parity_err when the sent
  // parity bit breaks even parity (never without a parity bit);
  // frame_err when the stop bit is low.
  task automatic send_frame(input bit sel, input logic [7:0] data,
                            input logic par_bit, input logic stop_bit);
    logic pe;
    pe = sel ? 1'b0 : (par_bit ^ (^data));
    if (sel) exp_n.push_back({~stop_bit, pe, data});
    else     exp_p.push_back({~stop_bit, pe, data});
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (!sel) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
  endtask

  initial begin
    int         n0;
    logic [7:0] d;
    logic       bad;
    logic       stp;

    rst     = 1'b0;
    if_p.rx = 1'b1;
    if_n.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout",       32'(if_p.dout),       32'h0);
    chk("rst_dout_vld",   32'(if_p.dout_vld),   32'h0);
    chk("rst_parity_err", 32'(if_p.parity_err), 32'h0);
    chk("rst_frame_err",  32'(if_p.frame_err),  32'h0);
    chk("rst_busy",       32'(if_p.busy),       32'h0);
    chk("rst_busy_np",    32'(if_n.busy),       32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // clean frame
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    idle(1'b0, 2);

    // wrong parity, then correct parity clears the flag
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1);
    idle(1'b0, 2);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    idle(1'b0, 2);

    // stop bit low, line held low: break
    send_frame(1'b0, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b0, 1'b0);
      chk("break_busy", 32'(if_p.busy), 32'h1);
    end
    set_rx(1'b0, 1'b1);
    repeat (6) @(negedge clk);
    chk("break_exit_busy", 32'(if_p.busy), 32'h0);
    idle(1'b0, 2);

    // glitch shorter than half a bit
    set_rx(1'b0, 1'b0);
    repeat (12) @(negedge clk);
    set_rx(1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("glitch_busy_high", 32'(if_p.busy), 32'h1);
    repeat (40) @(negedge clk);
    chk("glitch_busy_low", 32'(if_p.busy), 32'h0);
    idle(1'b0, 1);

    // back-to-back, parity build (11-bit frames)
    n0 = vld_cyc_p.size();
    send_frame(1'b0, 8'h00, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
    idle(1'b0, 2);
    chk("b2b_count_p", 32'(vld_cyc_p.size() - n0), 32'd2);
    if (vld_cyc_p.size() >= n0 + 2)
      chk("b2b_spacing_p", 32'(vld_cyc_p[n0+1] - vld_cyc_p[n0]), 32'(11 * BIT_CLK));

    // back-to-back, no-parity build (10-bit frames)
    n0 = vld_cyc_n.size();
    send_frame(1'b1, 8'h00, 1'b0, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b1);
    idle(1'b1, 2);
    chk("b2b_count_np", 32'(vld_cyc_n.size() - n0), 32'd2);
    if (vld_cyc_n.size() >= n0 + 2)
      chk("b2b_spacing_np", 32'(vld_cyc_n[n0+1] - vld_cyc_n[n0]), 32'(10 * BIT_CLK));

    // reset in the middle of data bit 4; the rest of the frame keeps the
    // line high so nothing after the reset looks like a start edge
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    set_rx(1'b0, 1'b1);
    repeat (BIT_CLK / 2) @(negedge clk);
    chk("pre_rst_busy", 32'(if_p.busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst_dout",       32'(if_p.dout),       32'h0);
    chk("midrst_dout_vld",   32'(if_p.dout_vld),   32'h0);
    chk("midrst_parity_err", 32'(if_p.parity_err), 32'h0);
    chk("midrst_frame_err",  32'(if_p.frame_err),  32'h0);
    chk("midrst_busy",       32'(if_p.busy),       32'h0);
    chk("midrst_dout_np",    32'(if_n.dout),       32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (BIT_CLK / 2 - 3) @(negedge clk);
    idle(1'b0, 6);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    idle(1'b0, 2);

    // random frames, parity build
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(1'b0, d, (^d) ^ bad, stp);
      idle(1'b0, int'($urandom_range(1, 3)));
    end

    // random frames, no-parity build
    for (int i = 0; i < 8; i++) begin
      d   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 4) != 0);
      send_frame(1'b1, d, 1'b0, stp);
      idle(1'b1, int'($urandom_range(1, 3)));
    end

    idle(1'b0, 2);
    chk("pending_p",  32'(exp_p.size()), 32'h0);
    chk("pending_np", 32'(exp_n.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
